// File: rtl/display_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_gen_pkg
//  Description : Shared VGA 640x480@60 timing constants, raster counter width,
//                12-bit colour type with WHITE/BLACK for the overlay blocks,
//                and a counter-window helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_timing_gen_pkg;

    // Default VGA 640x480@60 timing (pixels / lines)
    localparam int c_DEF_H_VISIBLE = 640;
    localparam int c_DEF_H_FP      = 16;
    localparam int c_DEF_H_SYNC    = 96;
    localparam int c_DEF_H_BP      = 48;
    localparam int c_DEF_V_VISIBLE = 480;
    localparam int c_DEF_V_FP      = 10;
    localparam int c_DEF_V_SYNC    = 2;
    localparam int c_DEF_V_BP      = 33;

    localparam int c_DEF_H_TOTAL = c_DEF_H_VISIBLE + c_DEF_H_FP + c_DEF_H_SYNC + c_DEF_H_BP;
    localparam int c_DEF_V_TOTAL = c_DEF_V_VISIBLE + c_DEF_V_FP + c_DEF_V_SYNC + c_DEF_V_BP;

    // Raster counter width (max count 799) and clock-divider counter width (CLK_DIV <= 16)
    localparam int c_CNT_W = 10;
    localparam int c_DIV_W = 4;

    // 12-bit RGB colour returned by the overlay blocks
    typedef logic [11:0] colour_t;
    localparam colour_t c_WHITE = 12'hFFF;
    localparam colour_t c_BLACK = 12'h000;

    // True when lo <= cnt < lo + len
    function automatic logic in_window(input logic [c_CNT_W-1:0] cnt, input int lo, input int len);
        int v;
        v = int'({22'd0, cnt});
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage : display_timing_gen_pkg
`default_nettype wire

// File: rtl/display_timing_gen_pixel_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_tick_gen
//  Description : Clock divider. Counts 0..CLK_DIV-1 and raises o_tick for the
//                single clk cycle in which the count sits at CLK_DIV-1.
//                With CLK_DIV = 1 the tick is high every cycle.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-high reset
//                o_tick - pixel-advance enable (combinational from the count)
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_gen
    import display_timing_gen_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;

    assign o_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (o_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

endmodule : pixel_tick_gen
`default_nettype wire

// File: rtl/display_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_gen
//  Description : VGA raster timing generator. Produces the current pixel
//                location plus sync, blanking and line/frame start strobes.
//  Ports       : clk         - system clock
//                reset       - asynchronous active-high reset
//                pix_tick    - one-clk pulse per pixel advance
//                pix_col     - horizontal counter 0..H_TOTAL-1
//                pix_row     - vertical counter 0..V_TOTAL-1
//                video_on    - high inside the visible area
//                hsync/vsync - sync pulses, active level SYNC_POL
//                line_start  - one-clk pulse when pix_col wraps to 0
//                frame_start - one-clk pulse when both counters wrap to (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module display_timing_gen
    import display_timing_gen_pkg::*;
#(
    parameter int   H_VISIBLE = c_DEF_H_VISIBLE,
    parameter int   H_FP      = c_DEF_H_FP,
    parameter int   H_SYNC    = c_DEF_H_SYNC,
    parameter int   H_BP      = c_DEF_H_BP,
    parameter int   V_VISIBLE = c_DEF_V_VISIBLE,
    parameter int   V_FP      = c_DEF_V_FP,
    parameter int   V_SYNC    = c_DEF_V_SYNC,
    parameter int   V_BP      = c_DEF_V_BP,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CLK_DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_tick,
    output logic [c_CNT_W-1:0] pix_col,
    output logic [c_CNT_W-1:0] pix_row,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int c_H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_H_SYNC_START = H_VISIBLE + H_FP;
    localparam int c_V_SYNC_START = V_VISIBLE + V_FP;

    localparam logic [c_CNT_W-1:0] c_H_LAST = c_CNT_W'(c_H_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST = c_CNT_W'(c_V_TOTAL - 1);

    logic               w_tick;
    logic               w_adv;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_started_next;
    logic [c_CNT_W-1:0] w_h_next;
    logic [c_CNT_W-1:0] w_v_next;

    // r_started is clear until the first tick after reset. That first tick
    // puts pixel (0,0) on screen without advancing, so (0,0) is displayed
    // CLK_DIV cycles after release and every later tick moves one pixel.
    logic               r_started;
    logic [c_CNT_W-1:0] r_h_cnt;
    logic [c_CNT_W-1:0] r_v_cnt;
    logic               r_pix_tick;
    logic               r_video_on;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .rst    (reset),
        .o_tick (w_tick)
    );

    always_comb begin
        w_adv          = w_tick & r_started;
        w_h_last       = (r_h_cnt == c_H_LAST);
        w_v_last       = (r_v_cnt == c_V_LAST);
        w_started_next = r_started | w_tick;
        w_h_next       = r_h_cnt;
        w_v_next       = r_v_cnt;
        if (w_adv) begin
            w_h_next = w_h_last ? '0 : r_h_cnt + c_CNT_W'(1);
            if (w_h_last) begin
                w_v_next = w_v_last ? '0 : r_v_cnt + c_CNT_W'(1);
            end
        end
    end

    // Every output is loaded from the next-state counters so that it lines
    // up with pix_col/pix_row on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_started     <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_pix_tick    <= 1'b0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_started     <= w_started_next;
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_pix_tick    <= w_tick;
            r_video_on    <= w_started_next
                             && in_window(w_h_next, 0, H_VISIBLE)
                             && in_window(w_v_next, 0, V_VISIBLE);
            r_hsync       <= in_window(w_h_next, c_H_SYNC_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= in_window(w_v_next, c_V_SYNC_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_line_start  <= w_adv & w_h_last;
            r_frame_start <= w_adv & w_h_last & w_v_last;
        end
    end

    assign pix_tick    = r_pix_tick;
    assign pix_col     = r_h_cnt;
    assign pix_row     = r_v_cnt;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule : display_timing_gen
`default_nettype wire

// File: tb/tb_display_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timing_gen
//  Description : Self-checking bench for display_timing_gen. Four instances
//                share clk/reset: default timing at CLK_DIV 4 and 1, and a
//                reduced raster (24x13) at CLK_DIV 1 with both sync
//                polarities. A closed-form raster model derived from the
//                number of clk edges since reset release produces the
//                expected outputs, queued at posedge and compared at negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_timing_gen;

    // {pix_tick, pix_col, pix_row, video_on, hsync, vsync, line_start, frame_start}
    typedef logic [25:0] vec_t;
    typedef logic [103:0] exp_t;

    typedef struct {
        int   d;
        int   hv, hfp, hs, hb;
        int   vv, vfp, vs, vb;
        logic pol;
    } cfg_t;

    logic clk;
    logic rst;

    logic       w_pix_tick    [4];
    logic [9:0] w_pix_col     [4];
    logic [9:0] w_pix_row     [4];
    logic       w_video_on    [4];
    logic       w_hsync       [4];
    logic       w_vsync       [4];
    logic       w_line_start  [4];
    logic       w_frame_start [4];
    vec_t       w_got         [4];

    cfg_t c_cfg [4];
    exp_t r_sb_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int r_n      = 0;

    // Per-phase observations
    int hs_low1, vid_low1, ls1, vs_low_s, fs_s, max_row_s, first_col1_d4, first_vid_d4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    display_timing_gen #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .reset(rst), .pix_tick(w_pix_tick[0]), .pix_col(w_pix_col[0]),
        .pix_row(w_pix_row[0]), .video_on(w_video_on[0]), .hsync(w_hsync[0]),
        .vsync(w_vsync[0]), .line_start(w_line_start[0]), .frame_start(w_frame_start[0])
    );

    display_timing_gen #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(rst), .pix_tick(w_pix_tick[1]), .pix_col(w_pix_col[1]),
        .pix_row(w_pix_row[1]), .video_on(w_video_on[1]), .hsync(w_hsync[1]),
        .vsync(w_vsync[1]), .line_start(w_line_start[1]), .frame_start(w_frame_start[1])
    );

    display_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CLK_DIV(1)
    ) u_small (
        .clk(clk), .reset(rst), .pix_tick(w_pix_tick[2]), .pix_col(w_pix_col[2]),
        .pix_row(w_pix_row[2]), .video_on(w_video_on[2]), .hsync(w_hsync[2]),
        .vsync(w_vsync[2]), .line_start(w_line_start[2]), .frame_start(w_frame_start[2])
    );

    display_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CLK_DIV(1)
    ) u_small_pol (
        .clk(clk), .reset(rst), .pix_tick(w_pix_tick[3]), .pix_col(w_pix_col[3]),
        .pix_row(w_pix_row[3]), .video_on(w_video_on[3]), .hsync(w_hsync[3]),
        .vsync(w_vsync[3]), .line_start(w_line_start[3]), .frame_start(w_frame_start[3])
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
        assign w_got[gi] = {w_pix_tick[gi], w_pix_col[gi], w_pix_row[gi], w_video_on[gi],
                            w_hsync[gi], w_vsync[gi], w_line_start[gi], w_frame_start[gi]};
    end

    // Expected outputs after n clk edges with reset low.
    function automatic vec_t model(input int n, input cfg_t c);
        int   ht, vt, k, p, col, row;
        logic tick, vid, hs, vs, ls, fs;
        if (n < c.d) return {1'b0, 10'd0, 10'd0, 1'b0, ~c.pol, ~c.pol, 2'b00};
        ht   = c.hv + c.hfp + c.hs + c.hb;
        vt   = c.vv + c.vfp + c.vs + c.vb;
        k    = n / c.d;
        p    = (k - 1) % (ht * vt);
        col  = p % ht;
        row  = p / ht;
        tick = (n % c.d) == 0;
        vid  = (col < c.hv) && (row < c.vv);
        hs   = (col >= c.hv + c.hfp && col < c.hv + c.hfp + c.hs) ? c.pol : ~c.pol;
        vs   = (row >= c.vv + c.vfp && row < c.vv + c.vfp + c.vs) ? c.pol : ~c.pol;
        ls   = tick && (k >= 2) && (col == 0);
        fs   = ls && (row == 0);
        return {tick, 10'(col), 10'(row), vid, hs, vs, ls, fs};
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
            if (n_errors >= 40) finish_sim();
        end
    endtask

    task automatic clear_stats();
        hs_low1 = 0; vid_low1 = 0; ls1 = 0; vs_low_s = 0; fs_s = 0;
        max_row_s = 0; first_col1_d4 = -1; first_vid_d4 = -1;
    endtask

    // One clk cycle: queue expectations at posedge, compare at negedge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst) r_n = 0;
        else     r_n++;
        r_sb_q.push_back({model(r_n, c_cfg[3]), model(r_n, c_cfg[2]),
                          model(r_n, c_cfg[1]), model(r_n, c_cfg[0])});
        @(negedge clk);
        e = r_sb_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("inst%0d n=%0d", i, r_n), w_got[i], e[i*26 +: 26]);
        end
        if (!rst && r_n >= 1) begin
            if (r_n <= 800) begin
                if (!w_hsync[1])    hs_low1++;
                if (!w_video_on[1]) vid_low1++;
            end
            if (r_n <= 801 && w_line_start[1]) ls1++;
            if (r_n <= 625) begin
                if (!w_vsync[2])      vs_low_s++;
                if (w_frame_start[2]) fs_s++;
            end
            if (int'(w_pix_row[2]) > max_row_s) max_row_s = int'(w_pix_row[2]);
            if (first_col1_d4 < 0 && w_pix_col[0] == 10'd1) first_col1_d4 = r_n;
            if (first_vid_d4 < 0 && w_video_on[0])          first_vid_d4 = r_n;
        end
    endtask

    task automatic check_phase(input string ph, input logic full);
        check_eq({ph, " d1 hsync low cycles"},   vec_t'(hs_low1),       vec_t'(96));
        check_eq({ph, " d1 video_on low cycles"}, vec_t'(vid_low1),     vec_t'(160));
        check_eq({ph, " d1 line_start count"},   vec_t'(ls1),           vec_t'(1));
        check_eq({ph, " small vsync low cycles"}, vec_t'(vs_low_s),     vec_t'(96));
        check_eq({ph, " small frame_start count"}, vec_t'(fs_s),        vec_t'(2));
        check_eq({ph, " d4 first col 1 edge"},   vec_t'(first_col1_d4), vec_t'(8));
        check_eq({ph, " d4 first video_on edge"}, vec_t'(first_vid_d4), vec_t'(4));
        if (full) check_eq({ph, " small max row"}, vec_t'(max_row_s),   vec_t'(12));
    endtask

    initial begin
        int waited;
        c_cfg[0] = '{d: 4, hv: 640, hfp: 16, hs: 96, hb: 48, vv: 480, vfp: 10, vs: 2, vb: 33, pol: 1'b0};
        c_cfg[1] = '{d: 1, hv: 640, hfp: 16, hs: 96, hb: 48, vv: 480, vfp: 10, vs: 2, vb: 33, pol: 1'b0};
        c_cfg[2] = '{d: 1, hv: 16, hfp: 2, hs: 4, hb: 2, vv: 8, vfp: 1, vs: 2, vb: 2, pol: 1'b0};
        c_cfg[3] = '{d: 1, hv: 16, hfp: 2, hs: 4, hb: 2, vv: 8, vfp: 1, vs: 2, vb: 2, pol: 1'b1};

        rst = 1'b1;
        clear_stats();
        for (int i = 0; i < 3; i++) step();

        // Phase A: run from reset release
        rst = 1'b0;
        for (int i = 0; i < 6500; i++) step();
        check_phase("A", 1'b1);

        // Walk the reduced raster to row 5, col 19 (inside hsync)
        waited = 0;
        while (!(w_pix_row[2] == 10'd5 && w_pix_col[2] == 10'd19) && waited < 400) begin
            step();
            waited++;
        end
        check_eq("reach mid-frame point", vec_t'(waited < 400), vec_t'(1));
        check_eq("small hsync active before reset", vec_t'(w_hsync[2]), vec_t'(0));

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("inst%0d async reset", i), w_got[i], model(0, c_cfg[i]));
        end
        for (int i = 0; i < 2; i++) step();

        // Phase B: timing after release must match phase A
        clear_stats();
        rst = 1'b0;
        for (int i = 0; i < 900; i++) step();
        check_phase("B", 1'b0);

        finish_sim();
    end

endmodule : tb_display_timing_gen
`default_nettype wire

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Produces VGA 640x480@60 raster timing and the current pixel location (pix_row, pix_col).
- Drives every overlay/sprite block in the racing game, such as the you-win, score and car image blocks, and the VGA connector.
- Consumers register pix_row/pix_col and return 12-bit colour. This block is the source end of that pixel-location interface.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CLK_DIV, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); legal values 1..16

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pix_tick  output  1  one-clk pulse marking each pixel advance
pix_col  output  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
pix_row  output  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
video_on  output  1  high while pix_col < H_VISIBLE and pix_row < V_VISIBLE
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
line_start  output  1  one-clk pulse when pix_col wraps to 0
frame_start  output  1  one-clk pulse when both counters wrap to (0,0)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high, and clears all state immediately.
- Reset values: div counter 0, h_cnt 0, v_cnt 0; pix_col 0, pix_row 0; video_on 0, pix_tick 0, line_start 0, frame_start 0; hsync = vsync = ~SYNC_POL (inactive).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - The internal tick is high in the clk cycle where div == CLK_DIV-1.
  - With CLK_DIV = 1 the tick is high every cycle.
- Horizontal counter: h_cnt advances only on tick. At H_TOTAL-1 it wraps to 0; otherwise it increments.
- Vertical counter: v_cnt advances only on a tick where h_cnt == H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- Output registers: every output is registered from the next-state counter values. Outputs therefore change in the same clk edge as the counters, with zero added latency versus the counters. pix_tick mirrors the internal tick, delayed by one register.
- hsync = SYNC_POL when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (columns 656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL when V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (rows 490..491); otherwise ~SYNC_POL.
- pix_col/pix_row report raw counters, including blanking. Consumers must gate colour with video_on.
- line_start: asserted for exactly one clk, on the edge where h_cnt becomes 0 due to a wrap. It is not asserted on reset release.
- frame_start: asserted together with line_start when v_cnt also wraps to 0. At most one pulse per frame.
- Timing totals: frame period = H_TOTAL*V_TOTAL*CLK_DIV clk cycles (1,680,000 at the defaults). Pixel (0,0) is first displayed CLK_DIV cycles after reset deassertion.
- Reset mid-frame: all outputs return to their reset values asynchronously. Counting restarts at (0,0) with no residual sync pulse or start pulse.
- Widths: 10-bit counters with no overflow (max 799). H_TOTAL and V_TOTAL are derived as localparams from the porch parameters.

Decomposition:
- Shared package holds the VGA timing constants (the default visible, porch and sync values), H_TOTAL/V_TOTAL, and the 12-bit colour constants WHITE/BLACK used by the overlay blocks.
- One sub-module: pixel_tick_gen, the CLK_DIV counter that produces the tick, with its own async reset.

Test Plan:
- Reset, then idle 3 clk with reset held -> pix_col = 0, pix_row = 0, video_on = 0, hsync = vsync = 1, no pulses.
- CLK_DIV = 4, release reset -> pix_tick every 4th clk; pix_col reaches 1 on the 8th clk edge after release; video_on = 1 from the first tick.
- CLK_DIV = 1, run one line -> hsync low exactly for pix_col 656..751 (96 cycles); video_on low for pix_col 640..799; line_start pulses once when pix_col goes 799 -> 0 and pix_row goes 0 -> 1.
- CLK_DIV = 1, run two frames -> vsync low for pix_row 490..491 (1600 cycles); frame_start pulses exactly once per 420,000 cycles; pix_row never exceeds 524.
- Assert reset at pix_row = 300, pix_col = 700 (hsync active) -> hsync goes to 1 and counters clear without waiting for clk; after release, timing is identical to the first frame.
- CLK_DIV = 1, SYNC_POL = 1 -> hsync/vsync pulses are high in the same windows, otherwise low.
